// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the two requesters, the UART transmitter and the scheduler.
// The scheduler connects through the slave modport. The bench or the system side connects through master.
interface uart_tx_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16
);
    logic                  rf_req;
    logic [DATA_WIDTH-1:0] rf_data;
    logic                  rf_ack;
    logic                  alu_req;
    logic [ALU_WIDTH-1:0]  alu_data;
    logic                  alu_ack;
    logic                  tx_busy;
    logic [DATA_WIDTH-1:0] tx_p_data;
    logic                  tx_data_valid;
    logic                  sched_busy;

    modport master (
        output rf_req, rf_data, alu_req, alu_data, tx_busy,
        input  rf_ack, alu_ack, tx_p_data, tx_data_valid, sched_busy
    );

    modport slave (
        input  rf_req, rf_data, alu_req, alu_data, tx_busy,
        output rf_ack, alu_ack, tx_p_data, tx_data_valid, sched_busy
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter between RF read data and ALU results.
// The scheduler sends one byte at a time, LSB byte first. If tx_busy does not rise in time, it re-sends the same byte.
module uart_tx_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int ALU_WIDTH   = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_scheduler_if.slave bus
);
    localparam int NBYTES = ALU_WIDTH / DATA_WIDTH;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] WAIT_HI = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ALU_WIDTH-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]      left_q, left_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic                  prio_alu_q, prio_alu_d;
    logic [DATA_WIDTH-1:0] tx_p_data_q, tx_p_data_d;
    logic                  tx_dv_q, tx_dv_d;
    logic                  rf_ack_q, rf_ack_d;
    logic                  alu_ack_q, alu_ack_d;
    logic                  grant_rf, grant_alu;
    logic [ALU_WIDTH-1:0]  shifted;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        buf_d       = buf_q;
        left_d      = left_q;
        to_d        = to_q;
        prio_alu_d  = prio_alu_q;
        tx_p_data_d = tx_p_data_q;
        tx_dv_d     = 1'b0;
        rf_ack_d    = 1'b0;
        alu_ack_d   = 1'b0;
        grant_rf    = 1'b0;
        grant_alu   = 1'b0;
        shifted     = buf_q >> DATA_WIDTH;

        // The outputs are registered on entry to LOAD, so they are valid for exactly the LOAD cycle.
        case (state_q)
            IDLE: begin
                if (!bus.tx_busy) begin
                    if (bus.rf_req && bus.alu_req) begin
                        grant_alu = prio_alu_q;
                        grant_rf  = !prio_alu_q;
                    end else begin
                        grant_rf  = bus.rf_req;
                        grant_alu = bus.alu_req;
                    end
                    if (grant_rf) begin
                        buf_d      = ALU_WIDTH'(bus.rf_data);
                        left_d     = CNT_W'(1);
                        prio_alu_d = 1'b1;
                        rf_ack_d   = 1'b1;
                    end else if (grant_alu) begin
                        buf_d      = bus.alu_data;
                        left_d     = CNT_W'(NBYTES);
                        prio_alu_d = 1'b0;
                        alu_ack_d  = 1'b1;
                    end
                    if (grant_rf || grant_alu) begin
                        tx_dv_d     = 1'b1;
                        tx_p_data_d = buf_d[DATA_WIDTH-1:0];
                        state_d     = LOAD;
                    end
                end
            end
            LOAD: begin
                to_d    = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else if (to_q == TO_W'(ACK_TIMEOUT - 1)) begin
                    tx_dv_d     = 1'b1;
                    tx_p_data_d = buf_q[DATA_WIDTH-1:0];
                    state_d     = LOAD;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: begin
                if (!bus.tx_busy) begin
                    buf_d  = shifted;
                    left_d = left_q - 1'b1;
                    if (left_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        tx_dv_d     = 1'b1;
                        tx_p_data_d = shifted[DATA_WIDTH-1:0];
                        state_d     = LOAD;
                    end
                end
            end
        endcase
    end

    // NOTE: use non-blocking assignments for state, so every flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            left_q      <= '0;
            to_q        <= '0;
            prio_alu_q  <= 1'b0;
            tx_p_data_q <= '0;
            tx_dv_q     <= 1'b0;
            rf_ack_q    <= 1'b0;
            alu_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            left_q      <= left_d;
            to_q        <= to_d;
            prio_alu_q  <= prio_alu_d;
            tx_p_data_q <= tx_p_data_d;
            tx_dv_q     <= tx_dv_d;
            rf_ack_q    <= rf_ack_d;
            alu_ack_q   <= alu_ack_d;
        end
    end

    assign bus.rf_ack        = rf_ack_q;
    assign bus.alu_ack       = alu_ack_q;
    assign bus.tx_p_data     = tx_p_data_q;
    assign bus.tx_data_valid = tx_dv_q;
    assign bus.sched_busy    = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboarded bench for uart_tx_scheduler. A small UART TX model answers each strobe with a busy window.
// The monitor pops the expected bytes and acks when the DUT produces them.
module tb_uart_tx_scheduler;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int TO    = 8;
    localparam int FRAME = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.DATA_WIDTH(DW), .ALU_WIDTH(AW)) bus ();

    uart_tx_scheduler #(.DATA_WIDTH(DW), .ALU_WIDTH(AW), .ACK_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic model_en    = 1'b1;
    logic forced_busy = 1'b0;
    logic model_busy  = 1'b0;
    assign bus.tx_busy = model_en ? model_busy : forced_busy;

    logic [DW-1:0] exp_bytes[$];
    bit            exp_acks[$];   // 0 = RF, 1 = ALU

    always @(posedge clk) cyc <= cyc + 1;

    // UART TX model: a strobe seen in a LOAD cycle holds busy for FRAME cycles.
    initial begin : tx_model
        int left;
        left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                model_busy = 1'b0;
                left       = 0;
            end else if (left > 0) begin
                left--;
                if (left == 0) model_busy = 1'b0;
            end else if (model_en && bus.tx_data_valid) begin
                model_busy = 1'b1;
                left       = FRAME;
            end
        end
    end

    initial begin : monitor
        logic [DW-1:0] exp_b;
        bit            tag;
        forever begin
            @(negedge clk);
            if (rst_n && bus.tx_data_valid) begin
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: got byte %h, none expected", bus.tx_p_data);
                end else begin
                    exp_b = exp_bytes.pop_front();
                    if (bus.tx_p_data !== exp_b) begin
                        errors++;
                        $display("FAIL tx_byte: got %h expected %h", bus.tx_p_data, exp_b);
                    end
                end
            end
            if (rst_n && (bus.rf_ack || bus.alu_ack)) begin
                checks++;
                if (bus.rf_ack && bus.alu_ack) begin
                    errors++;
                    $display("FAIL ack_both: rf_ack=%b alu_ack=%b expected one", bus.rf_ack, bus.alu_ack);
                end else if (exp_acks.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: rf_ack=%b alu_ack=%b, none expected", bus.rf_ack, bus.alu_ack);
                end else begin
                    tag = exp_acks.pop_front();
                    if (bus.alu_ack !== tag) begin
                        errors++;
                        $display("FAIL ack_source: got alu_ack=%b expected alu_ack=%b", bus.alu_ack, tag);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit alu, input string name);
        int n;
        n = 0;
        while (n < 500 && !(alu ? bus.alu_ack : bus.rf_ack)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((alu ? bus.alu_ack : bus.rf_ack) !== 1'b1) begin
            errors++;
            $display("FAIL %s: ack not seen within 500 cycles (alu=%0d)", name, alu);
        end
        if (alu) bus.alu_req = 1'b0;
        else     bus.rf_req  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.sched_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: sched_busy=%b expected 0 within 500 cycles", name, bus.sched_busy);
        end
    endtask

    task automatic check_queues(input string name);
        checks++;
        if (exp_bytes.size() != 0 || exp_acks.size() != 0) begin
            errors++;
            $display("FAIL %s: pending bytes=%0d acks=%0d expected 0 and 0", name, exp_bytes.size(), exp_acks.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.tx_data_valid, bus.rf_ack, bus.alu_ack, bus.sched_busy, bus.tx_p_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got dv=%b rf=%b alu=%b busy=%b data=%h expected all 0",
                     bus.tx_data_valid, bus.rf_ack, bus.alu_ack, bus.sched_busy, bus.tx_p_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: sched_busy=%b expected 0", bus.sched_busy);
        end
    endtask

    task automatic test_rf_single();
        exp_bytes.push_back(8'hA5);
        exp_acks.push_back(1'b0);
        tick();
        bus.rf_req  = 1'b1;
        bus.rf_data = 8'hA5;
        @(negedge clk);
        checks++;
        if (bus.rf_ack !== 1'b0) begin
            errors++;
            $display("FAIL rf_latency_early: rf_ack=%b expected 0", bus.rf_ack);
        end
        @(negedge clk);
        checks++;
        if ({bus.rf_ack, bus.tx_data_valid, bus.sched_busy, bus.tx_p_data} !== {3'b111, 8'hA5}) begin
            errors++;
            $display("FAIL rf_grant: got ack=%b dv=%b busy=%b data=%h expected 1 1 1 a5",
                     bus.rf_ack, bus.tx_data_valid, bus.sched_busy, bus.tx_p_data);
        end
        bus.rf_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.rf_ack, bus.tx_data_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rf_pulse: got ack=%b dv=%b expected 0 0", bus.rf_ack, bus.tx_data_valid);
        end
        wait_idle("rf_done");
        checks++;
        if (bus.tx_p_data !== 8'hA5) begin
            errors++;
            $display("FAIL rf_hold: tx_p_data=%h expected a5", bus.tx_p_data);
        end
        check_queues("rf_queue");
    endtask

    task automatic test_alu_two_bytes();
        exp_bytes.push_back(8'h34);
        exp_bytes.push_back(8'h12);
        exp_acks.push_back(1'b1);
        tick();
        bus.alu_req  = 1'b1;
        bus.alu_data = 16'h1234;
        wait_ack(1'b1, "alu_ack");
        wait_idle("alu_done");
        checks++;
        if (bus.tx_p_data !== 8'h12) begin
            errors++;
            $display("FAIL alu_hold: tx_p_data=%h expected 12", bus.tx_p_data);
        end
        check_queues("alu_queue");
    endtask

    task automatic test_round_robin();
        test_reset();
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        exp_bytes.push_back(8'h33);
        exp_bytes.push_back(8'h44);
        exp_acks.push_back(1'b0);
        exp_acks.push_back(1'b1);
        exp_acks.push_back(1'b0);
        tick();
        bus.rf_req   = 1'b1;
        bus.rf_data  = 8'h11;
        bus.alu_req  = 1'b1;
        bus.alu_data = 16'h3322;
        wait_ack(1'b0, "rr_first_rf");
        tick();
        bus.rf_req  = 1'b1;
        bus.rf_data = 8'h44;
        fork
            wait_ack(1'b1, "rr_alu");
            wait_ack(1'b0, "rr_second_rf");
        join
        wait_idle("rr_done");
        check_queues("rr_queue");
    endtask

    task automatic test_back_to_back_timeout();
        int t0;
        int t1;
        int n;
        model_en    = 1'b0;
        forced_busy = 1'b0;
        repeat (3) exp_bytes.push_back(8'h3C);
        exp_acks.push_back(1'b0);
        tick();
        bus.rf_req  = 1'b1;
        bus.rf_data = 8'h3C;
        wait_ack(1'b0, "to_ack");
        t0 = cyc;
        n  = 0;
        @(negedge clk);
        while (!bus.tx_data_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        checks++;
        if (bus.tx_data_valid !== 1'b1 || (t1 - t0) != TO + 1) begin
            errors++;
            $display("FAIL timeout_resend: dv=%b gap=%0d expected dv=1 gap=%0d", bus.tx_data_valid, t1 - t0, TO + 1);
        end
        model_en = 1'b1;
        wait_idle("to_done");
        check_queues("to_queue");
    endtask

    task automatic test_reset_mid_frame();
        int strobes;
        exp_bytes.push_back(8'hEF);
        exp_acks.push_back(1'b1);
        tick();
        bus.alu_req  = 1'b1;
        bus.alu_data = 16'hBEEF;
        wait_ack(1'b1, "mid_ack");
        repeat (3) @(negedge clk);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.tx_data_valid, bus.rf_ack, bus.alu_ack, bus.sched_busy, bus.tx_p_data} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got dv=%b rf=%b alu=%b busy=%b data=%h expected all 0",
                     bus.tx_data_valid, bus.rf_ack, bus.alu_ack, bus.sched_busy, bus.tx_p_data);
        end
        tick();
        tick();
        rst_n   = 1'b1;
        strobes = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.tx_data_valid || bus.sched_busy) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL mid_no_resume: busy/strobe cycles=%0d expected 0", strobes);
        end
        check_queues("mid_queue");
    endtask

    task automatic test_busy_idle();
        int grants;
        model_en    = 1'b0;
        forced_busy = 1'b1;
        exp_bytes.push_back(8'h5A);
        exp_acks.push_back(1'b0);
        tick();
        bus.rf_req  = 1'b1;
        bus.rf_data = 8'h5A;
        grants = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rf_ack || bus.sched_busy) grants++;
        end
        checks++;
        if (grants != 0) begin
            errors++;
            $display("FAIL busy_hold: grant cycles=%0d expected 0", grants);
        end
        tick();
        forced_busy = 1'b0;
        model_en    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rf_ack !== 1'b0) begin
            errors++;
            $display("FAIL busy_early: rf_ack=%b expected 0", bus.rf_ack);
        end
        @(negedge clk);
        checks++;
        if ({bus.rf_ack, bus.tx_data_valid} !== 2'b11) begin
            errors++;
            $display("FAIL busy_release: got ack=%b dv=%b expected 1 1", bus.rf_ack, bus.tx_data_valid);
        end
        bus.rf_req = 1'b0;
        wait_idle("busy_done");
        check_queues("busy_queue");
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rf_req   = 1'b0;
        bus.rf_data  = '0;
        bus.alu_req  = 1'b0;
        bus.alu_data = '0;
        test_reset();
        test_rf_single();
        test_alu_two_bytes();
        test_round_robin();
        test_back_to_back_timeout();
        test_reset_mid_frame();
        test_busy_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
